// File: rtl/mux_pkg.sv
// Shared select/arbitration types.
// arb_mode_t: SEL, PRIO, RR, reserved.
package mux_pkg;

  typedef enum logic [1:0] {
    MODE_SEL  = 2'b00,
    MODE_PRIO = 2'b01,
    MODE_RR   = 2'b10,
    MODE_RSVD = 2'b11
  } arb_mode_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way grant: explicit, fixed-priority or round-robin.
// In: req, ptr, mode, s. Out: gnt_valid, gnt_idx.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  arb_mode_t       mode,
  input  logic [SELW-1:0] s,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  int rr_j;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    rr_j      = 0;
    unique case (mode)
      MODE_SEL: begin
        // s beyond N-1 matches no channel
        for (int i = 0; i < N; i++) begin
          if (SELW'(i) == s && req[i]) begin
            gnt_valid = 1'b1;
            gnt_idx   = SELW'(i);
          end
        end
      end
      MODE_PRIO: begin
        for (int i = 0; i < N; i++) begin
          if (!gnt_valid && req[i]) begin
            gnt_valid = 1'b1;
            gnt_idx   = SELW'(i);
          end
        end
      end
      MODE_RR: begin
        // scan ptr, ptr+1, ... wrapping at N
        for (int k = 0; k < N; k++) begin
          rr_j = int'(ptr) + k;
          if (rr_j >= N) rr_j = rr_j - N;
          if (!gnt_valid && req[rr_j]) begin
            gnt_valid = 1'b1;
            gnt_idx   = SELW'(rr_j);
          end
        end
      end
      MODE_RSVD: begin
        gnt_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Registered N:1 flow-controlled mux stage with selectable arbitration.
// Ports: clk, rst, mode, s, in_valid/in_data/in_ready, out_*.
module rr_arb_mux
  import mux_pkg::*;
#(
  parameter  int SIZE = 32,
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  arb_mode_t       mode,
  input  logic [SELW-1:0] s,
  input  logic [N-1:0]    in_valid,
  input  logic [SIZE-1:0] in_data [N],
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [SIZE-1:0] out_data,
  output logic [SELW-1:0] out_ch,
  input  logic            out_ready
);

  logic            load;
  logic            xfer;
  logic            gnt_valid;
  logic [SELW-1:0] gnt_idx;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] ptr_nxt;
  logic [SIZE-1:0] sel_data;

  assign load = !out_valid || out_ready;

  rr_arbiter #(.N(N)) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .mode      (mode),
    .s         (s),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (SELW'(i) == gnt_idx) begin
        sel_data = in_data[i];
        in_ready[i] = !rst && load && gnt_valid;
      end
    end
  end

  // a grant only exists for a valid request
  assign xfer = |in_ready;

  assign ptr_nxt = (gnt_idx == SELW'(N - 1))
                 ? '0 : gnt_idx + SELW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else begin
      if (load) begin
        out_valid <= xfer;
        if (xfer) begin
          out_data <= sel_data;
          out_ch   <= gnt_idx;
        end
      end
      if (xfer && mode == MODE_RR) begin
        ptr <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux (N=4 and N=3 builds).
// Hand-computed expectations for each vector.
module tb_rr_arb_mux;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arb_mode_t   mode;
  logic [1:0]  s;
  logic [3:0]  in_valid;
  logic [31:0] in_data [4];
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  arb_mode_t   mode3;
  logic [1:0]  s3;
  logic [2:0]  in_valid3;
  logic [31:0] in_data3 [3];
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [31:0] out_data3;
  logic [1:0]  out_ch3;
  logic        out_ready3;

  rr_arb_mux #(.SIZE(32), .N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .s         (s),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  rr_arb_mux #(.SIZE(32), .N(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode3),
    .s         (s3),
    .in_valid  (in_valid3),
    .in_data   (in_data3),
    .in_ready  (in_ready3),
    .out_valid (out_valid3),
    .out_data  (out_data3),
    .out_ch    (out_ch3),
    .out_ready (out_ready3)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    mode       = MODE_RR;
    s          = 2'd0;
    in_valid   = 4'b0000;
    out_ready  = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i] = 32'hA0 + i;
    mode3      = MODE_PRIO;
    s3         = 2'd0;
    in_valid3  = 3'b000;
    out_ready3 = 1'b1;
    for (int i = 0; i < 3; i++) in_data3[i] = 32'hB0 + i;
    step();
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_ch", 32'(out_ch), 32'd0);
    rst = 1'b0;

    // round-robin, all requesting
    in_valid = 4'b1111;
    #1;
    check("rr_rdy0", 32'(in_ready), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_valid", 32'(out_valid), 32'd1);
      check("rr_ch", 32'(out_ch), 32'(i % 4));
      check("rr_data", out_data, 32'hA0 + (i % 4));
    end

    // fixed priority: ch1 starves ch3
    mode = MODE_PRIO;
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("prio_rdy", 32'(in_ready), 32'h2);
      step();
      check("prio_ch", 32'(out_ch), 32'd1);
    end
    in_valid = 4'b1000;
    #1;
    check("prio_rdy3", 32'(in_ready), 32'h8);
    step();
    check("prio_ch3", 32'(out_ch), 32'd3);
    check("prio_d3", out_data, 32'hA3);

    // explicit select
    mode = MODE_SEL;
    s = 2'd2;
    in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sel_rdy", 32'(in_ready), 32'h4);
      step();
      check("sel_ch", 32'(out_ch), 32'd2);
    end

    // backpressure
    s = 2'd0;
    in_valid = 4'b0001;
    in_data[0] = 32'hDEAD;
    step();
    check("bp_load", out_data, 32'hDEAD);
    out_ready = 1'b0;
    in_data[0] = 32'hBEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rdy", 32'(in_ready), 32'h0);
      step();
      check("bp_data", out_data, 32'hDEAD);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_rdy", 32'(in_ready), 32'h1);
    step();
    check("bp_next", out_data, 32'hBEEF);
    check("bp_next_v", 32'(out_valid), 32'd1);
    in_valid = 4'b0000;
    in_data[0] = 32'hA0;
    step();
    check("bp_drain", 32'(out_valid), 32'd0);

    // wrap-around: ptr is 1 here; ch2 win moves it to 3
    mode = MODE_RR;
    in_valid = 4'b0100;
    step();
    check("wr_pre", 32'(out_ch), 32'd2);
    in_valid = 4'b0001;
    #1;
    check("wr_rdy", 32'(in_ready), 32'h1);
    step();
    check("wr_ch", 32'(out_ch), 32'd0);
    in_valid = 4'b1111;
    #1;
    check("wr_ptr1", 32'(in_ready), 32'h2);
    step();
    check("wr_ch1", 32'(out_ch), 32'd1);

    // reset mid-transfer
    rst = 1'b1;
    #1;
    check("mr_rdy", 32'(in_ready), 32'h0);
    check("mr_rdy3", 32'(in_ready3), 32'h0);
    step();
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_data", out_data, 32'd0);
    check("mr_ch", 32'(out_ch), 32'd0);
    rst = 1'b0;
    #1;
    check("mr_ptr0", 32'(in_ready), 32'h1);
    step();
    check("mr_ch0", 32'(out_ch), 32'd0);
    in_valid = 4'b0000;

    // N=3 build, select beyond range
    in_valid3 = 3'b111;
    step();
    check("n3_load", 32'(out_valid3), 32'd1);
    check("n3_ch", 32'(out_ch3), 32'd0);
    mode3 = MODE_SEL;
    s3 = 2'd3;
    #1;
    check("n3_rdy", 32'(in_ready3), 32'h0);
    step();
    check("n3_drain", 32'(out_valid3), 32'd0);
    check("n3_rdy2", 32'(in_ready3), 32'h0);
    step();
    check("n3_idle", 32'(out_valid3), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised, registered N:1 channel multiplexer with valid/ready handshakes on every input and on the output. It generalises the pipeline's 4:1 operand/result select into a flow-controlled stage. The winning input is chosen either by an explicit select, by fixed priority, or by round-robin. The block is used wherever several pipeline sources contend for one downstream consumer, for example IF/MEM requests to a shared memory port.

## Interface
- `SIZE`, default 32: data width in bits.
- `N`, default 4: number of input channels, N >= 2.
- `SELW`, default $clog2(N): select/channel-index width (derived, not overridden).

Ports:
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `mode` input 2: arbitration mode (`arb_mode_t`).
- `s` input SELW: explicit channel select, used in MODE_SEL only.
- `in_valid` input N: per-channel request.
- `in_data` input N x SIZE: per-channel payload, unpacked array [N].
- `in_ready` output N: per-channel accept; at most one bit high.
- `out_valid` output 1: output register holds data.
- `out_data` output SIZE: registered payload.
- `out_ch` output SELW: index of the channel that produced `out_data`.
- `out_ready` input 1: downstream accept.

## Operation
- Single output register stage: `out_valid`, `out_data`, `out_ch`.
- `load = !out_valid || out_ready`. Arbitration runs only when `load` is high; otherwise every `in_ready` bit is 0.
- Grant `g` is computed combinationally in the same cycle. `in_ready[g] = load && in_valid[g]`.
- A transfer on channel g happens when `in_valid[g] && in_ready[g]`. On that edge, `out_data <= in_data[g]`, `out_ch <= g`, `out_valid <= 1`.
- If `load` is high and no channel transfers, `out_valid <= 0`.
- Modes:
  - MODE_SEL (2'b00): only channel `s` is eligible. If `s >= N`, nothing is eligible.
  - MODE_PRIO (2'b01): the lowest-index valid channel wins.
  - MODE_RR (2'b10): the first valid channel at or after `ptr`, wrapping N-1 -> 0, wins.
  - 2'b11 (reserved): no grant. `in_ready` stays all-zero and the output drains normally.
- Round-robin pointer `ptr` (SELW bits):
  - On a transfer in MODE_RR, `ptr <= (g == N-1) ? 0 : g+1`.
  - `ptr` is not updated in the other modes and holds its value across mode changes.
- Inputs must hold `in_valid`/`in_data` until accepted. The block does not check this.

## Timing
- Reset (synchronous, takes priority over everything): `out_valid = 0`, `out_data = 0`, `out_ch = 0`, `ptr = 0`. `in_ready` is forced to 0 during any cycle with `rst` high.
- Latency: input accepted at edge k appears on the output in the cycle after edge k (1 cycle).
- Throughput: 1 transfer/cycle while `out_ready` stays high.
- Backpressure: while `out_valid && !out_ready`, `out_data`/`out_ch` are stable and all `in_ready` = 0.
- Simultaneous output drain and input accept in the same cycle: the new data replaces the old with no bubble.
- `mode`/`s` changes take effect in the arbitration of the same cycle and never alter an already-registered output.
- Reset asserted mid-transfer: pending output data is discarded and no `in_ready` is issued during that cycle.

## Structure
- Package `mux_pkg`: `arb_mode_t` enum (MODE_SEL, MODE_PRIO, MODE_RR, MODE_RSVD). Shared with other select logic.
- Sub-module `rr_arbiter`, parameter N:
  - Inputs: `req[N]`, `ptr`, `mode`, `s`.
  - Outputs: `gnt_valid`, `gnt_idx`.
  - Purely combinational.
- Top level holds the output register, the `ptr` register and the handshake logic.

## Test plan
- Reset, then MODE_RR, N=4, all `in_valid` = 1, `out_ready` = 1, `in_data[i]` = 32'hA0+i. Required: `out_ch` sequence 0,1,2,3,0 on consecutive cycles, with `out_data` = 32'hA0..A3.
- MODE_PRIO, `in_valid` = 4'b1010. Required: ch1 is accepted every cycle and ch3 starves. Then drop ch1: ch3 is accepted next.
- MODE_SEL, `s` = 2, `in_valid` = 4'b1111. Required: only `in_ready[2]` ever asserts. Then N=3 build with `s` = 3: `in_ready` stays 0 and `out_valid` falls to 0 after the drain.
- Backpressure: accept 32'hDEAD, then hold `out_ready` = 0 for 5 cycles. Required: `out_data` stable at 32'hDEAD, `in_ready` = 0. On release, the next word appears one cycle later with no loss and no duplicate.
- MODE_RR with `ptr` = 3 and `in_valid` = 4'b0001. Required: ch0 is granted (wrap-around) and `ptr` becomes 1.
- Assert `rst` while `out_valid` = 1 and inputs are valid. Required: the next cycle shows `out_valid` = 0, `out_data` = 0, `out_ch` = 0, with no `in_ready` asserted during the reset cycle. `ptr` = 0 is confirmed by the first RR grant after reset going to ch0.
